// File: rtl/td4_pkg.sv
// td4_pkg: shared TD4 loader types and widths.
package td4_pkg;
  localparam int TD4_ADDR_W   = 4;
  localparam int TD4_NIBBLE_W = 4;
  localparam int TD4_WORDS    = 16;
  typedef enum logic [2:0] {IDLE, WAIT_OP, WAIT_IMM, WRITE, DONE} loader_state_t;
endpackage

// File: rtl/sync_rise.sv
// sync_rise: multi-flop synchronizer with a registered one-cycle rising-edge pulse.
module sync_rise #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_pulse
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_pulse;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[STAGES-2:0], i_d};
      r_prev  <= r_sync[STAGES-1];
      r_pulse <= r_sync[STAGES-1] & ~r_prev;
    end
  end
  assign o_pulse = r_pulse;
endmodule

// File: rtl/program_loader.sv
// program_loader: strobe-clocked nibble pairs written to consecutive TD4 program words.
module program_loader
  import td4_pkg::*;
#(
  parameter int WORDS       = TD4_WORDS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_en,
  input  logic                    strobe,
  input  logic [TD4_NIBBLE_W-1:0] nibble,
  output logic [TD4_ADDR_W-1:0]   mem_address,
  output logic [TD4_NIBBLE_W-1:0] mem_opcode,
  output logic [TD4_NIBBLE_W-1:0] mem_immediate,
  output logic                    mem_write,
  output logic                    cpu_hold,
  output logic                    load_done
);
  localparam logic [TD4_ADDR_W-1:0] LAST = TD4_ADDR_W'(WORDS - 1);
  loader_state_t             r_state;
  logic [TD4_ADDR_W-1:0]     r_addr;
  logic [TD4_NIBBLE_W-1:0]   r_op;
  logic [TD4_NIBBLE_W-1:0]   r_imm;
  logic                      r_done;
  logic                      w_pulse;
  sync_rise #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_d     (strobe),
    .o_pulse (w_pulse)
  );
  // Abort has priority over a coincident strobe pulse in the waiting states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_op    <= '0;
      r_imm   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (load_en) begin
          r_state <= WAIT_OP;
          r_addr  <= '0;
          r_done  <= 1'b0;
        end
        WAIT_OP: if (!load_en) r_state <= IDLE;
          else if (w_pulse) begin
            r_op    <= nibble;
            r_state <= WAIT_IMM;
          end
        WAIT_IMM: if (!load_en) r_state <= IDLE;
          else if (w_pulse) begin
            r_imm   <= nibble;
            r_state <= WRITE;
          end
        WRITE: if (r_addr == LAST) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end else begin
          r_addr  <= r_addr + 1'b1;
          r_state <= WAIT_OP;
        end
        DONE: if (!load_en) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign mem_address   = r_addr;
  assign mem_opcode    = r_op;
  assign mem_immediate = r_imm;
  assign mem_write     = r_state == WRITE;
  assign cpu_hold      = r_state != IDLE;
  assign load_done     = r_done;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized scoreboard bench for program_loader.
module tb_program_loader;
  logic       clk = 1'b0;
  logic       rst, load_en, strobe;
  logic [3:0] nibble;
  logic [3:0] mem_address, mem_opcode, mem_immediate;
  logic       mem_write, cpu_hold, load_done;

  typedef struct {
    logic [3:0] a;
    logic [3:0] o;
    logic [3:0] i;
    bit         last;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_addr = 0;
  logic [3:0] m_op = 4'd0;
  logic [3:0] m_imm = 4'd0;

  program_loader dut (
    .clk           (clk),
    .rst           (rst),
    .load_en       (load_en),
    .strobe        (strobe),
    .nibble        (nibble),
    .mem_address   (mem_address),
    .mem_opcode    (mem_opcode),
    .mem_immediate (mem_immediate),
    .mem_write     (mem_write),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    @(negedge clk);
    nibble = n;
    strobe = 1'b1;
    repeat (6) @(negedge clk);
    strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_word(input logic [3:0] op, input logic [3:0] imm);
    q.push_back('{a: 4'(m_addr), o: op, i: imm, last: (m_addr == 15)});
    m_op  = op;
    m_imm = imm;
    if (m_addr < 15) m_addr++;
  endtask

  task automatic send_word(input logic [3:0] op, input logic [3:0] imm);
    send_nib(op);
    expect_word(op, imm);
    send_nib(imm);
  endtask

  task automatic start_load();
    @(negedge clk);
    load_en = 1'b1;
    m_addr  = 0;
    @(negedge clk);
    chk("start_hold", cpu_hold, 1);
    chk("start_done_clear", load_done, 0);
  endtask

  task automatic stop_load();
    @(negedge clk);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every write pulse must match the oldest expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_write === 1'b1) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got write at addr %0d op %0d imm %0d expected none",
                   mem_address, mem_opcode, mem_immediate);
        end else begin
          e = q.pop_front();
          chk("wr_addr", mem_address, e.a);
          chk("wr_op", mem_opcode, e.o);
          chk("wr_imm", mem_immediate, e.i);
          chk("wr_hold", cpu_hold, 1);
          chk("wr_done_low", load_done, 0);
          if (e.last) begin
            @(negedge clk);
            chk("done_after_last", load_done, 1);
            chk("single_pulse", mem_write, 0);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] op, imm;
    rst = 1'b1; load_en = 1'b0; strobe = 1'b0; nibble = 4'd0;
    repeat (2) begin
      @(negedge clk);
      load_en = 1'($urandom);
      strobe  = 1'($urandom);
      nibble  = 4'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; load_en = 1'b0; strobe = 1'b0;
    chk("rst_addr", mem_address, 0);
    chk("rst_op", mem_opcode, 0);
    chk("rst_imm", mem_immediate, 0);
    chk("rst_write", mem_write, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", load_done, 0);
    repeat (6) @(negedge clk);
    chk("rst_no_capture", mem_opcode, 0);

    start_load();
    for (int i = 0; i < 16; i++) send_word(4'(i), 4'(15 - i));
    @(negedge clk);
    chk("full_done", load_done, 1);
    chk("full_hold", cpu_hold, 1);
    chk("full_addr_stop", mem_address, 15);
    stop_load();
    chk("drop_hold", cpu_hold, 0);
    chk("drop_done_sticky", load_done, 1);

    send_nib(4'd9);
    send_nib(4'd6);
    chk("idle_ignore_op", mem_opcode, m_op);
    chk("idle_ignore_imm", mem_immediate, m_imm);
    chk("idle_done_sticky", load_done, 1);

    start_load();
    for (int i = 0; i < 5; i++) send_word(4'($urandom), 4'($urandom));
    op = 4'($urandom);
    send_nib(op);
    stop_load();
    repeat (8) @(negedge clk);
    chk("abort_hold", cpu_hold, 0);
    chk("abort_done", load_done, 0);
    chk("abort_op", mem_opcode, op);
    chk("abort_addr", mem_address, 5);

    start_load();
    chk("restart_addr", mem_address, 0);
    send_word(4'($urandom), 4'($urandom));
    op  = 4'($urandom);
    imm = 4'($urandom);
    @(negedge clk);
    nibble = op;
    strobe = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_op", mem_opcode, op);
    strobe = 1'b0;
    repeat (2) @(negedge clk);
    expect_word(op, imm);
    send_nib(imm);

    while (m_addr < 7) send_word(4'($urandom), 4'($urandom));
    send_nib(4'($urandom));
    chk("mid_addr7", mem_address, 7);
    @(negedge clk);
    rst = 1'b1;
    load_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_write", mem_write, 0);
    chk("midrst_addr", mem_address, 0);
    chk("midrst_hold", cpu_hold, 0);
    chk("midrst_op", mem_opcode, 0);
    repeat (8) @(negedge clk);

    start_load();
    for (int i = 0; i < 16; i++) send_word(4'($urandom), 4'($urandom));
    @(negedge clk);
    chk("rand_done", load_done, 1);
    send_nib(4'($urandom));
    send_nib(4'($urandom));
    chk("done_ignore_op", mem_opcode, m_op);
    chk("done_ignore_imm", mem_immediate, m_imm);
    chk("done_hold", cpu_hold, 1);
    stop_load();
    chk("final_hold", cpu_hold, 0);
    chk("missing_writes", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Upstream feeder for the TD4 program memory. Accepts program bytes from external pins as pairs of 4-bit nibbles (opcode then immediate) clocked in by an asynchronous strobe, and writes them into consecutive memory words starting at address 0. Holds the CPU core stalled while loading and flags completion once all words are written.

## Interface
- `WORDS`, default 16: number of memory words per load. Addresses run 0..WORDS-1, and WORDS must be at most 16.
- `SYNC_STAGES`, default 2: flip-flop depth of the strobe synchronizer.
- `clk` in 1: single system clock. All state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_en` in 1: level input requesting load mode. Its source is clk-synchronous.
- `strobe` in 1: asynchronous pin. Each rising edge presents one nibble.
- `nibble` in 4: data nibble. Must be stable from before the strobe rising edge until SYNC_STAGES+2 cycles after it.
- `mem_address` out 4: memory word address.
- `mem_opcode` out 4: opcode nibble to memory.
- `mem_immediate` out 4: immediate nibble to memory.
- `mem_write` out 1: one-cycle write pulse to memory.
- `cpu_hold` out 1: high while a load is in progress. Stalls the CPU core.
- `load_done` out 1: high after a complete load. Sticky until the next load starts.

## Operation
- FSM states and transitions:
  - IDLE: if `load_en`=1, go to WAIT_OP, set `mem_address`=0 and clear `load_done`.
  - WAIT_OP: on a strobe edge pulse, capture `nibble` into `mem_opcode` and go to WAIT_IMM.
  - WAIT_IMM: on an edge pulse, capture `nibble` into `mem_immediate` and go to WRITE.
  - WRITE: `mem_write`=1 for exactly this cycle.
    - If `mem_address`==WORDS-1, go to DONE.
    - Otherwise increment `mem_address` and go to WAIT_OP.
  - DONE: set `load_done`=1. When `load_en`=0, go to IDLE.
- `cpu_hold`=1 in WAIT_OP, WAIT_IMM, WRITE and DONE. `cpu_hold`=0 in IDLE.
- Abort: `load_en`=0 in WAIT_OP or WAIT_IMM returns the FSM to IDLE next cycle.
  - No write occurs and `load_done` stays 0.
  - Words already written stay in memory.
- `load_en`=0 during WRITE does not cancel that write. The abort is taken from the following state.
- Strobe edge pulses are ignored in IDLE, WRITE and DONE. Host rule: successive strobe rising edges at least 3 clk apart.
- A strobe held high yields exactly one capture. The edge detector fires only on a 0→1 transition of the synchronized signal.
- Address wrap: `mem_address` never increments past WORDS-1. The next load restarts at 0.
- `mem_opcode` and `mem_immediate` retain their last captured values outside the write cycle.
- `rst` in any state: FSM goes to IDLE and all registers clear, including the synchronizer and edge-detect flops. No `mem_write` is issued in the reset cycle.
- Reset values: `mem_address`=0, `mem_opcode`=0, `mem_immediate`=0, `mem_write`=0, `cpu_hold`=0, `load_done`=0.

## Timing
- Strobe pin rise to internal edge pulse: SYNC_STAGES+1 cycles, i.e. 3 at the default.
- Capture happens on the edge-pulse cycle. The new state and captured nibble are visible the next cycle.
- `mem_write` is high in the cycle after the immediate is captured.
  - `mem_address`, `mem_opcode` and `mem_immediate` are stable for that entire cycle.
  - Memory samples them at the next rising edge.
- `mem_write` is decoded from the registered state only, with no combinational path from inputs.
- The `mem_address` increment takes effect the cycle after the write pulse.
- `load_done` rises one cycle after the last write pulse.
- `cpu_hold` rises one cycle after `load_en` is sampled high in IDLE. It falls one cycle after `load_en` is sampled low in DONE or in an abortable state.
- Minimum full load: 16×2 strobes. Each word's write pulse comes 1 cycle after its immediate capture.

## Structure
- Shared package `td4_pkg` holds:
  - the `loader_state_t` enum (IDLE, WAIT_OP, WAIT_IMM, WRITE, DONE);
  - the constants `TD4_ADDR_W`=4, `TD4_NIBBLE_W`=4 and `TD4_WORDS`=16.
- Sub-module `sync_rise`: SYNC_STAGES-deep synchronizer plus a registered rising-edge detect, with synchronous reset. Outputs a one-cycle pulse.
- Top level contains the FSM, the address counter and the capture registers.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with random inputs → all outputs 0 and state IDLE. Strobe edges during reset produce no capture.
- Full load: `load_en`=1, send word i as op=i, imm=15-i for i=0..15 → 16 `mem_write` pulses.
  - Pulse i has address=i, opcode=i, immediate=15-i.
  - `load_done`=1 one cycle after pulse 15, and `cpu_hold`=1 throughout.
  - Drop `load_en` → `cpu_hold`=0, `load_done` stays 1.
- Abort: load 5 words, send one opcode nibble, then drop `load_en` → IDLE with no 6th write, `load_done`=0, `cpu_hold`=0. A new load starts writing at address 0.
- Held strobe: keep `strobe` high for 20 cycles in WAIT_OP → exactly one capture and state WAIT_IMM.
- Reset mid-load: assert `rst` in WAIT_IMM at address 7 → no write, address 0, IDLE next cycle.
- Ignored edges: strobe pulses in IDLE and DONE → no capture and no `mem_write`. Raising `load_en` from IDLE after DONE clears `load_done` one cycle later.
